// File: rtl/hex_overlay.sv
// hex_overlay: renders DIGITS hex digits of a frame-synchronised value as an 8x8 font overlay
module hex_overlay #(
    parameter int DIGITS = 4,
    parameter int X0     = 16,
    parameter int Y0     = 16,
    parameter int SCALE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixEn,
    input  logic [9:0]            hPos,
    input  logic [9:0]            vPos,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  valueStb,
    output logic                  pixOut,
    output logic                  overlayActive
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int TOTAL = DIGITS * (8 << SCALE);
    // ink rows 1..6 per glyph, first row in the top byte; rows 0 and 7 are implicit blanks
    localparam logic [15:0][47:0] FONT = {
        48'h7E607C606060, 48'h7E607C60607E, 48'h786C66666C78, 48'h3C666060663C,
        48'h7C667C66667C, 48'h183C66667E66, 48'h3C66663E063C, 48'h3C663C66663C,
        48'h7E060C183030, 48'h3C607C66663C, 48'h7E607C06663C, 48'h0C1C3C6C7E0C,
        48'h7E0C180C663C, 48'h3C660C18307E, 48'h18381818187E, 48'h3C666E76663C
    };
    state_t state_q, state_d;
    logic [9:0] pos_q, pos_d, cur, dy;
    logic [4*DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic flag_q, flag_d, pix_q, pix_d, act_q, act_d;
    logic frame_start, in_win, running, active, last;
    logic [3:0] dig, nib;
    logic [2:0] col, row;
    logic [7:0] glyph_row;
    assign frame_start = pixEn && hPos == 10'd0 && vPos == 10'd0;
    assign dy          = vPos - 10'(Y0);
    assign in_win      = vPos >= 10'(Y0) && dy < 10'(8 << SCALE);
    assign running     = state_q == RUN && hPos != 10'd0;
    assign active      = running || (hPos == 10'(X0) && in_win);
    // cur is the overlay pixel index of the current hPos; a fresh start always renders index 0
    assign cur         = running ? pos_q : 10'd0;
    assign last        = cur == 10'(TOTAL - 1);
    assign dig         = 4'(cur >> (SCALE + 3));
    assign col         = 3'(cur >> SCALE);
    assign row         = 3'(dy >> SCALE);
    assign nib         = 4'(disp_q >> (4 * (DIGITS - 1 - int'(dig))));
    assign glyph_row   = 8'({FONT[nib], 8'h00} >> (8 * (7 - int'(row))));
    assign pixOut        = pix_q;
    assign overlayActive = act_q;
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        pix_d   = pix_q;
        act_d   = act_q;
        if (pixEn) begin
            state_d = active && !last ? RUN : IDLE;
            pos_d   = active && !last ? cur + 10'd1 : 10'd0;
            act_d   = active;
            pix_d   = active && glyph_row[3'd7 - col];
        end
        pend_d = valueStb ? value : pend_q;
        flag_d = valueStb ? !frame_start : flag_q && !frame_start;
        disp_d = !frame_start ? disp_q : valueStb ? value : flag_q ? pend_q : disp_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            flag_q  <= 1'b0;
            pix_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            flag_q  <= flag_d;
            pix_q   <= pix_d;
            act_q   <= act_d;
        end
    end
endmodule

// File: tb/tb_hex_overlay.sv
// tb_hex_overlay: scoreboard bench driving pixel streams into a SCALE=0 and a SCALE=1 overlay
module tb_hex_overlay;
    logic clk = 1'b0;
    logic reset, pixEn, valueStb;
    logic [9:0] hPos, vPos;
    logic [15:0] value;
    logic pix0, act0, pix1, act1;

    hex_overlay dut0 (
        .clk(clk), .reset(reset), .pixEn(pixEn), .hPos(hPos), .vPos(vPos),
        .value(value), .valueStb(valueStb), .pixOut(pix0), .overlayActive(act0)
    );
    hex_overlay #(.SCALE(1)) dut1 (
        .clk(clk), .reset(reset), .pixEn(pixEn), .hPos(hPos), .vPos(vPos),
        .value(value), .valueStb(valueStb), .pixOut(pix1), .overlayActive(act1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] e0;
        logic [1:0] e1;
    } exp_t;
    exp_t q[$];
    exp_t ex;
    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] disp_m = 16'h0, pend_m = 16'h0;
    bit pflag_m = 1'b0;
    logic [1:0] last0 = 2'b00, last1 = 2'b00;
    logic [47:0] font_tb [16] = '{
        48'h3C666E76663C, 48'h18381818187E, 48'h3C660C18307E, 48'h7E0C180C663C,
        48'h0C1C3C6C7E0C, 48'h7E607C06663C, 48'h3C607C66663C, 48'h7E060C183030,
        48'h3C663C66663C, 48'h3C66663E063C, 48'h183C66667E66, 48'h7C667C66667C,
        48'h3C666060663C, 48'h786C66666C78, 48'h7E607C60607E, 48'h7E607C606060
    };

    function automatic void chk(string name, logic [1:0] got, logic [1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: act/pix got %b required %b (t=%0t hPos=%0d vPos=%0d)",
                      name, got, want, $time, hPos, vPos);
    endfunction

    // expected {overlayActive, pixOut} for a pixel of a continuously scanned line
    function automatic logic [1:0] model(int sc, logic [15:0] d, int v, int h);
        int w, rel, dg, col, row;
        logic [3:0] nib;
        logic [7:0] r;
        w = 8 << sc;
        if (v < 16 || v >= 16 + w || h < 16 || h >= 16 + 4 * w) return 2'b00;
        rel = h - 16;
        dg  = rel / w;
        col = (rel % w) >> sc;
        row = (v - 16) >> sc;
        nib = 4'(d >> (4 * (3 - dg)));
        r   = (row == 0 || row == 7) ? 8'h00 : 8'(font_tb[nib] >> (8 * (6 - row)));
        return {1'b1, r[7 - col]};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            ex = q.pop_front();
            chk("scale0_pixel", {act0, pix0}, ex.e0);
            chk("scale1_pixel", {act1, pix1}, ex.e1);
        end
    end

    task automatic cyc(input bit en, input int h, input int v, input bit stb,
                       input logic [15:0] val, input logic [1:0] e0, input logic [1:0] e1);
        @(negedge clk);
        pixEn = en; hPos = 10'(h); vPos = 10'(v); valueStb = stb; value = val;
        if (en) begin
            last0 = e0;
            last1 = e1;
        end
        q.push_back(exp_t'{e0: last0, e1: last1});
        if (en && h == 0 && v == 0) begin
            if (stb) disp_m = val;
            else if (pflag_m) disp_m = pend_m;
            pflag_m = 1'b0;
        end else if (stb) begin
            pend_m  = val;
            pflag_m = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; pixEn = 1'b0; valueStb = 1'b0;
        #1;
        chk("reset_async_scale0", {act0, pix0}, 2'b00);
        chk("reset_async_scale1", {act1, pix1}, 2'b00);
        last0 = 2'b00; last1 = 2'b00;
        disp_m = 16'h0; pend_m = 16'h0; pflag_m = 1'b0;
        repeat (2) cyc(1'b0, 0, 0, 1'b0, 16'h0, 2'b00, 2'b00);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic line(input int v, input int stb_h, input logic [15:0] sval,
                        input bit tog, input int rst_h, input bit hand);
        bit dead;
        logic [1:0] e0, e1;
        logic [7:0] p1, pf;
        logic [15:0] p0;
        dead = 1'b0; p1 = 8'h18; pf = 8'h7E; p0 = 16'h0FF0;
        for (int h = 0; h < 90; h++) begin
            e0 = dead ? 2'b00 : model(0, disp_m, v, h);
            e1 = dead ? 2'b00 : model(1, disp_m, v, h);
            if (hand && v == 17 && h >= 16 && h < 24) e0 = {1'b1, p1[23 - h]};
            if (hand && v == 17 && h >= 40 && h < 48) e0 = {1'b1, pf[47 - h]};
            if (hand && v == 18 && h >= 16 && h < 32) e1 = {1'b1, p0[31 - h]};
            cyc(1'b1, h, v, h == stb_h, h == stb_h ? sval : 16'h0, e0, e1);
            if (tog) cyc(1'b0, h, v, 1'b0, 16'h0, 2'b00, 2'b00);
            if (h == rst_h) begin
                @(posedge clk);
                #3;
                do_reset();
                dead = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b0; pixEn = 1'b0; valueStb = 1'b0; hPos = '0; vPos = '0; value = '0;
        #1;
        do_reset();
        cyc(1'b0, 100, 100, 1'b1, 16'h10AF, 2'b00, 2'b00);
        line(0, -1, 16'h0, 1'b0, -1, 1'b0);
        line(17, -1, 16'h0, 1'b0, -1, 1'b1);
        line(16, -1, 16'h0, 1'b0, -1, 1'b0);
        line(23, -1, 16'h0, 1'b0, -1, 1'b0);
        line(24, -1, 16'h0, 1'b0, -1, 1'b0);
        line(15, -1, 16'h0, 1'b0, -1, 1'b0);
        line(20, 50, 16'h1111, 1'b0, -1, 1'b0);
        line(17, -1, 16'h0, 1'b0, -1, 1'b1);
        line(0, -1, 16'h0, 1'b0, -1, 1'b0);
        line(17, -1, 16'h0, 1'b0, -1, 1'b0);
        line(0, 0, 16'h0000, 1'b0, -1, 1'b0);
        line(18, -1, 16'h0, 1'b0, -1, 1'b1);
        cyc(1'b0, 100, 100, 1'b1, 16'h3E5D, 2'b00, 2'b00);
        line(0, -1, 16'h0, 1'b0, -1, 1'b0);
        line(19, -1, 16'h0, 1'b1, -1, 1'b0);
        line(21, -1, 16'h0, 1'b0, -1, 1'b0);
        line(22, -1, 16'h0, 1'b1, -1, 1'b0);
        cyc(1'b0, 100, 100, 1'b1, 16'hB2C4, 2'b00, 2'b00);
        line(0, -1, 16'h0, 1'b0, -1, 1'b0);
        line(26, -1, 16'h0, 1'b0, -1, 1'b0);
        line(18, -1, 16'h0, 1'b0, 30, 1'b0);
        line(19, -1, 16'h0, 1'b0, -1, 1'b0);
        cyc(1'b0, 100, 100, 1'b1, 16'h6789, 2'b00, 2'b00);
        line(0, -1, 16'h0, 1'b0, -1, 1'b0);
        line(20, -1, 16'h0, 1'b0, -1, 1'b0);
        repeat (3) cyc(1'b0, 100, 100, 1'b0, 16'h0, 2'b00, 2'b00);
        @(posedge clk);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: entries left %0d required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hex_overlay.md
HEX_OVERLAY -- requirements
Module: hex_overlay

Interface
REQ-001 Parameter DIGITS, default 4; number of hex digits rendered, legal 1..16.
REQ-002 Parameter X0, default 16; first horizontal pixel of the overlay.
REQ-003 Parameter Y0, default 16; first vertical line of the overlay.
REQ-004 Parameter SCALE, default 0; glyph magnification is 2^SCALE, legal 0..2.
REQ-005 Port clk, input, 1 bit; the only clock.
REQ-006 Port reset, input, 1 bit; asynchronous, active-high.
REQ-007 Port pixEn, input, 1 bit; pixel-clock enable; all state advances only on clk edges with pixEn=1.
REQ-008 Port hPos, input, 10 bits; current horizontal pixel position.
REQ-009 Port vPos, input, 10 bits; current line.
REQ-010 Port value, input, 4*DIGITS bits; value to display, most-significant nibble leftmost.
REQ-011 Port valueStb, input, 1 bit; single-cycle capture strobe, sampled on every clk edge regardless of pixEn.
REQ-012 Port pixOut, output, 1 bit; 1 = ink pixel.
REQ-013 Port overlayActive, output, 1 bit; 1 = pixOut belongs to the overlay box.

Function
REQ-014 Internal font SHALL hold 16 glyphs (0-F), 8x8, row 0 and row 7 blank, bit 7 leftmost.
REQ-015 Glyph ink rows 1-6 SHALL be: '0' 3C 66 6E 76 66 3C; '1' 18 38 18 18 18 7E; 'A' 18 3C 66 66 7E 66; 'F' 7E 60 7C 60 60 60; other digits use the team's standard 8x8 hex set.
REQ-016 valueStb=1 SHALL copy value into a pending register and set pendFlag.
REQ-017 Frame start is pixEn=1 with hPos=0 and vPos=0.
REQ-018 At frame start with pendFlag=1, pending SHALL be copied to the display register and pendFlag cleared.
REQ-019 If valueStb coincides with frame start, value SHALL go directly to the display register and pendFlag SHALL end cleared.
REQ-020 Display register SHALL NOT change at any time other than frame start.
REQ-021 Row window: Y0 <= vPos < Y0 + (8<<SCALE); glyph row = (vPos-Y0)>>SCALE.
REQ-022 FSM states: IDLE, RUN.
REQ-023 IDLE->RUN on pixEn=1, hPos=X0, and vPos inside the row window; digit index, column index and repeat counter SHALL be cleared.
REQ-024 In RUN, each pixEn SHALL advance the repeat counter; on wrap at 2^SCALE the column advances; on column 7 wrap the digit index advances.
REQ-025 RUN->IDLE after DIGITS*8<<SCALE pixels, or immediately on pixEn=1 with hPos=0 (line abort).
REQ-026 pixOut and overlayActive SHALL be registered: latency exactly one pixEn cycle after the pixel's hPos is presented.
REQ-027 In RUN: overlayActive=1 and pixOut=font bit of the selected digit, row and column.
REQ-028 In IDLE: overlayActive=0 and pixOut=0.
REQ-029 pixEn=0 SHALL hold FSM, counters, pixOut and overlayActive unchanged.
REQ-030 Digit index d SHALL select nibble value[4*(DIGITS-1-d)+:4] of the display register.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, counters 0, display register 0, pending 0, pendFlag 0, pixOut 0, overlayActive 0.
REQ-032 Reset asserted mid-RUN SHALL abort the line; rendering resumes only at the next qualifying hPos=X0 after release.

Verification
REQ-033 Defaults, value=0x10AF, valueStb, frame start, vPos=17, hPos 16..23 -> pixOut 0,0,0,1,1,0,0,0 ('1' row 1 = 18); hPos 40..47 -> 0,1,1,1,1,1,1,0 ('F' row 1 = 7E).
REQ-034 Defaults, vPos=16 or vPos=23 -> overlayActive=1 for hPos 16..47 with pixOut all 0; vPos=24 -> overlayActive never 1.
REQ-035 SCALE=1, value 0x0000 -> row window vPos 16..31, 64 active pixels per line; vPos=18, hPos 16..31 -> pixOut 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0 ('0' row 1 = 3C doubled).
REQ-036 valueStb with 0x1111 at vPos=20 mid-frame -> frame continues showing the old value; next frame shows 0x1111; valueStb on frame-start cycle -> new value shown in that same frame.
REQ-037 pixEn toggling 1,0,1,0 during RUN -> the pixel sequence is identical to continuous pixEn, with each value held through pixEn=0 cycles.
REQ-038 reset pulsed at hPos=30 in RUN -> pixOut=0 and overlayActive=0 immediately without waiting for a clk edge; no output until the next line's hPos=16.
